mbe_mult_arbiter: RTL and testbench
===================================

Name: mbe_mult_arbiter

Overview:
- Shares one MBE radix-4 / Dadda-tree multiplier datapath between N_REQ requesters with round-robin arbitration.
- Wraps the combinational datapath in a 3-stage pipeline: operand register, carry/sum register, product register.
- Valid/ready handshakes on both sides. Results are tagged with the requester ID.
- Includes a halt/drain FSM so software can quiesce the multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- OP_W, 11, unsigned operand width; datapath is fixed at 6 partial products of 12 bits
- PROD_W, 22, product width (2*OP_W)
- ID_W, 2, requester tag width, $clog2(N_REQ)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_a  in  N_REQ*OP_W  packed multiplicands; requester i at [i*OP_W +: OP_W]
- req_b  in  N_REQ*OP_W  packed multipliers
- req_ready  out  N_REQ  one-hot accept; at most one bit high
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_prod  out  PROD_W  a*b, unsigned
- rsp_id  out  ID_W  index of originating requester
- halt_req  in  1  level; stop granting and drain
- halted  out  1  pipeline empty and FSM in HALT

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits cleared; rsp_valid=0, rsp_prod=0, rsp_id=0.
  - req_ready=0, halted=0.
  - RR pointer=0; FSM=RUN.
- Global advance: adv = !rsp_valid | rsp_ready. All three stages shift together when adv=1 and hold otherwise, including bubbles.
- Stage S1 captures the granted a, b and id, and s1_v=1 on a grant. On an adv cycle with no grant, s1_v=0.
- Stage S2 captures carry/sum from the MBE encoder plus dadda_tree, driven by the S1 operands, and s2_v=s1_v.
- Stage S3 (output) captures rsp_prod=carry+sum truncated to PROD_W, rsp_id, and rsp_valid=s2_v.
- Latency: grant at edge E0 gives rsp_valid=1 after edge E0+3 when no stall occurs. Throughput is 1 product per cycle.
- Arbitration (combinational):
  - Search from ptr upward with wrap-around for the first set req_valid bit.
  - req_ready[i]=1 only for that winner, and only when adv=1 and FSM=RUN.
  - On a handshake (req_valid[i] & req_ready[i]), ptr <= (i+1) mod N_REQ. Otherwise ptr holds.
- Requester rule: a requester must keep req_valid and its operands stable until ready. The arbiter does not depend on this.
- FSM:
  - RUN: grants allowed. halt_req=1 -> DRAIN, and no grant is issued in that same cycle.
  - DRAIN: no grants. When s1_v, s2_v and rsp_valid are all 0 -> HALT. halt_req=0 -> RUN, with grants resuming next cycle.
  - HALT: halted=1, no grants. halt_req=0 -> RUN, and halted drops the same edge.
- halt_req=1 while already empty: RUN -> DRAIN -> HALT, so halted=1 two edges later.
- A stall during DRAIN delays HALT until the consumer takes all results. No result is dropped.
- Mid-operation reset discards in-flight products; no response is issued for them.
- 2047*2047 = 4190209 fits in 22 bits. carry+sum overflow beyond PROD_W is discarded by construction.

Optional Feature:
- MULT_STATS_EN
  - Defined: adds ports stat_done (out, 16) and stat_stall (out, 16).
    - stat_done increments on each rsp_valid & rsp_ready.
    - stat_stall increments on each cycle with rsp_valid & !rsp_ready.
    - Both saturate at 16'hFFFF and reset to 0 on rst_n.
  - Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package mbe_mult_pkg:
  - constants OP_W=11, PP_W=12, N_PP=6, PROD_W=22
  - typedef arb_state_t enum {RUN, DRAIN, HALT}
  - typedef prod_t logic [PROD_W-1:0]
- Sub-module rr_arbiter (N_REQ parameter): inputs req, en, ptr; outputs one-hot grant and index.
- Existing MBE encoder and dadda_tree are instantiated unchanged between S1 and S2.

Test Plan:
- Single request: req0 a=1234, b=123, rsp_ready=1 -> rsp_valid 3 cycles after handshake, rsp_prod=151782, rsp_id=0.
- All 4 requesters valid continuously, with a=i+1 and b=10 -> grants in order 0,1,2,3,0,…; products 10,20,30,40 in order with matching IDs; one result per cycle.
- Backpressure: rsp_ready=0 for 5 cycles with a full pipeline -> rsp_prod/rsp_id held stable and req_ready=0. After release, no loss or duplication.
- Max operands a=2047, b=2047 -> 4190209. Zero operand a=0, b=1500 -> 0.
- halt_req=1 with 3 in flight -> no new grants; 3 results delivered; halted=1 after the pipeline empties. Deassert -> grants resume next cycle.
- Assert rst_n=0 mid-stream -> rsp_valid=0, req_ready=0 and halted=0 immediately. After release, first grant goes to requester 0; with MULT_STATS_EN, counters=0.

Source files
------------

// File: rtl/mbe_mult_pkg.sv
// Shared types, constants and MBE radix-4 / carry-save helpers for mbe_mult_arbiter.
// The datapath is fixed at 11-bit unsigned operands, 6 partial products of 12 bits.
package mbe_mult_pkg;

   localparam int unsigned OP_W   = 11;
   localparam int unsigned PP_W   = 12;
   localparam int unsigned N_PP   = 6;
   localparam int unsigned PROD_W = 22;

   typedef enum logic [1:0] {RUN, DRAIN, HALT} arb_state_t;

   typedef logic [PROD_W-1:0] prod_t;

   typedef struct packed {
      prod_t s;
      prod_t c;
   } csa_t;

   // One Booth digit times a, placed at weight 4^j.
   // Negative digits are ones'-complemented here; the +1 goes into the separate neg-bit row.
   function automatic prod_t mbe_pp(input logic [OP_W-1:0] a, input logic [2:0] grp,
                                    input int unsigned j);
      logic            one;
      logic            two;
      logic            neg;
      logic [PP_W-1:0] mag;
      prod_t           ext;
      one = grp[0] ^ grp[1];
      two = (grp[2] & ~grp[1] & ~grp[0]) | (~grp[2] & grp[1] & grp[0]);
      neg = grp[2];
      mag = one ? {1'b0, a} : (two ? {a, 1'b0} : '0);
      ext = neg ? {{(PROD_W-PP_W){1'b1}}, ~mag} : {{(PROD_W-PP_W){1'b0}}, mag};
      return ext << (2 * j);
   endfunction

   function automatic csa_t csa3(input prod_t x, input prod_t y, input prod_t z);
      csa_t r;
      r.s = x ^ y ^ z;
      r.c = ((x & y) | (x & z) | (y & z)) << 1;
      return r;
   endfunction

endpackage

// File: rtl/mbe_mult_arbiter_rr.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping around.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx,
   output logic             vld
);
   import mbe_mult_pkg::*;

   always_comb begin
      logic [ID_W-1:0] ci;
      grant = '0;
      idx   = '0;
      vld   = 1'b0;
      ci    = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         ci = ID_W'((32'(ptr) + k) % N_REQ);
         if (!vld && req[ci]) begin
            vld = 1'b1;
            idx = ci;
         end
      end
      if (en && vld) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/mbe_mult_arbiter.sv
// Round-robin shared MBE/Dadda multiplier, 3-stage pipeline, halt/drain FSM.
// Optional statistics counters (stat_done/stat_stall) are enabled by defining MULT_STATS_EN.
module mbe_mult_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned OP_W   = 11,
   parameter int unsigned PROD_W = 22,
   parameter int unsigned ID_W   = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*OP_W-1:0] req_a,
   input  logic [N_REQ*OP_W-1:0] req_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [PROD_W-1:0]     rsp_prod,
   output logic [ID_W-1:0]       rsp_id,
   input  logic                  halt_req,
   output logic                  halted
`ifdef MULT_STATS_EN
   ,
   output logic [15:0]           stat_done,
   output logic [15:0]           stat_stall
`endif
);
   import mbe_mult_pkg::*;

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d, gnt_idx;
   logic [ID_W-1:0]     s1_id_q, s2_id_q, rsp_id_q;
   logic                adv, gnt_en, gnt_vld, hs;
   logic [OP_W-1:0]     a_sel, b_sel, s1_a_q, s1_b_q;
   logic                s1_v_q, s2_v_q, rsp_valid_q;
   prod_t               tree_s, tree_c, s2_s_q, s2_c_q;
   logic [PROD_W-1:0]   rsp_prod_q, rsp_prod_d;
   prod_t               pp [N_PP+1];
   logic [OP_W+1:0]     bx;
   csa_t                t0, t1, t2, t3, t4;

   assign adv = !rsp_valid_q || rsp_ready;
   // rst_n gates grants so req_ready drops the instant reset asserts.
   assign gnt_en = rst_n && adv && (state_q == RUN) && !halt_req;
   assign hs     = gnt_en && gnt_vld;

   rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .req   (req_valid),
      .en    (gnt_en),
      .ptr   (ptr_q),
      .grant (req_ready),
      .idx   (gnt_idx),
      .vld   (gnt_vld)
   );

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            a_sel = a_sel | req_a[i*OP_W +: OP_W];
            b_sel = b_sel | req_b[i*OP_W +: OP_W];
         end
      end
      ptr_d = ptr_q;
      if (hs) ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
   end

   // Six Booth rows plus one row collecting the +1 of every negative digit, reduced 7 -> 2.
   always_comb begin
      bx       = {1'b0, s1_b_q, 1'b0};
      pp[N_PP] = '0;
      for (int unsigned j = 0; j < N_PP; j++) begin
         pp[j]            = mbe_pp(s1_a_q, bx[2*j +: 3], j);
         pp[N_PP][2*j]    = bx[2*j+2];
      end
      t0     = csa3(pp[0], pp[1], pp[2]);
      t1     = csa3(pp[3], pp[4], pp[5]);
      t2     = csa3(t0.s, t0.c, t1.s);
      t3     = csa3(t2.s, t2.c, t1.c);
      t4     = csa3(t3.s, t3.c, pp[N_PP]);
      tree_s = t4.s;
      tree_c = t4.c;
   end

   assign rsp_prod_d = PROD_W'(s2_c_q + s2_s_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (halt_req) state_d = DRAIN;
         DRAIN:   if (!halt_req) state_d = RUN;
                  else if (!s1_v_q && !s2_v_q && !rsp_valid_q) state_d = HALT;
         HALT:    if (!halt_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         ptr_q       <= '0;
         s1_v_q      <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_id_q     <= '0;
         s2_v_q      <= 1'b0;
         s2_s_q      <= '0;
         s2_c_q      <= '0;
         s2_id_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_prod_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (adv) begin
            s1_v_q <= hs;
            if (hs) begin
               s1_a_q  <= a_sel;
               s1_b_q  <= b_sel;
               s1_id_q <= gnt_idx;
            end
            s2_v_q      <= s1_v_q;
            s2_s_q      <= tree_s;
            s2_c_q      <= tree_c;
            s2_id_q     <= s1_id_q;
            rsp_valid_q <= s2_v_q;
            rsp_prod_q  <= rsp_prod_d;
            rsp_id_q    <= s2_id_q;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_prod  = rsp_prod_q;
   assign rsp_id    = rsp_id_q;
   assign halted    = (state_q == HALT);

`ifdef MULT_STATS_EN
   logic [15:0] done_q, stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q  <= '0;
         stall_q <= '0;
      end else begin
         if (rsp_valid_q && rsp_ready && done_q != '1)   done_q  <= done_q + 1'b1;
         if (rsp_valid_q && !rsp_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
      end
   end

   assign stat_done  = done_q;
   assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_mbe_mult_arbiter.sv
// Scoreboard bench for mbe_mult_arbiter: directed operands with hand-computed products.
module tb_mbe_mult_arbiter;
   localparam int N = 4;
   localparam int W = 11;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [21:0]    rsp_prod;
   logic [1:0]     rsp_id;
   logic           halt_req = 1'b0;
   logic           halted;
`ifdef MULT_STATS_EN
   logic [15:0]    stat_done, stat_stall;
`endif

   mbe_mult_arbiter #(.N_REQ(4), .OP_W(11), .PROD_W(22), .ID_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_prod(rsp_prod), .rsp_id(rsp_id), .halt_req(halt_req), .halted(halted)
`ifdef MULT_STATS_EN
      , .stat_done(stat_done), .stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int unsigned id; int unsigned prod; int unsigned cyc;} exp_t;
   typedef struct {int unsigned id; int unsigned cyc;} gnt_t;
   exp_t exp_q[$];
   gnt_t glog[$];

   logic [W-1:0] ops_a [N][16];
   logic [W-1:0] ops_b [N][16];
   int unsigned  ops_p [N][16];
   int unsigned  n_ops [N] = '{default: 0};
   int unsigned  rd    [N] = '{default: 0};

   int unsigned n_pass = 0, n_total = 0, n_rsp = 0, n_stall = 0;
   bit          chk_lat = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic add_op(input int i, input int unsigned a, input int unsigned b,
                         input int unsigned p);
      ops_a[i][n_ops[i]] = W'(a);
      ops_b[i][n_ops[i]] = W'(b);
      ops_p[i][n_ops[i]] = p;
      n_ops[i]++;
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (rd[i] != n_ops[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_idle(input string nm);
      int k = 0;
      while ((exp_q.size() != 0 || pending()) && k < 200) begin
         tick(1);
         k++;
      end
      chk(nm, 32'(k < 200), 1);
   endtask

   // Requester driver: logs handshakes at the negedge, advances operands after the edge.
   initial begin
      logic [N-1:0] hs;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      forever begin
         @(negedge clk);
         hs = req_valid & req_ready;
         for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
               exp_q.push_back('{id: i, prod: ops_p[i][rd[i]], cyc: cyc});
               glog.push_back('{id: i, cyc: cyc});
            end
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (hs[i]) rd[i]++;
            if (rd[i] < n_ops[i]) begin
               req_valid[i]     = 1'b1;
               req_a[i*W +: W]  = ops_a[i][rd[i]];
               req_b[i*W +: W]  = ops_b[i][rd[i]];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Response monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid && !rsp_ready) n_stall++;
         if (rst_n && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", {10'd0, rsp_prod}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id", 32'(rsp_id), e.id);
               chk("rsp_prod", 32'(rsp_prod), e.prod);
               if (chk_lat) chk("latency", cyc - e.cyc, 3);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_rsp_prod", 32'(rsp_prod), 0);
      chk("reset_rsp_id", 32'(rsp_id), 0);
      chk("reset_req_ready", 32'(req_ready), 0);
      chk("reset_halted", 32'(halted), 0);
      tick(1);
      rst_n = 1'b1;

      // All four requesters streaming: a=i+1, b=10.
      chk_lat = 1'b1;
      base = glog.size();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) add_op(i, i + 1, 10, (i + 1) * 10);
      wait_idle("stream_done");
      for (int k = 0; k < 8; k++) begin
         chk("grant_order", glog[base+k].id, k % 4);
         if (k > 0) chk("grant_back_to_back", glog[base+k].cyc - glog[base].cyc, k);
      end

      // Single request, then boundary operands.
      base = glog.size();
      add_op(0, 1234, 123, 151782);
      wait_idle("single_done");
      chk("single_grant_id", glog[base].id, 0);
      add_op(1, 2047, 2047, 4190209);
      add_op(2, 0, 1500, 0);
      add_op(3, 1365, 682, 930930);
      add_op(0, 2047, 1, 2047);
      wait_idle("boundary_done");

      // Backpressure with a full pipeline.
      chk_lat = 1'b0;
      rsp_ready = 1'b0;
      add_op(0, 100, 100, 10000);
      add_op(1, 255, 256, 65280);
      add_op(2, 2047, 1024, 2096128);
      add_op(3, 3, 7, 21);
      tick(8);
      chk("bp_inflight", exp_q.size(), 3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 1);
         chk("bp_req_ready", 32'(req_ready), 0);
         chk("bp_hold_prod", 32'(rsp_prod), exp_q[0].prod);
         chk("bp_hold_id", 32'(rsp_id), exp_q[0].id);
      end
      tick(1);
      rsp_ready = 1'b1;
      wait_idle("bp_done");
`ifdef MULT_STATS_EN
      chk("stat_done", 32'(stat_done), n_rsp);
      chk("stat_stall", 32'(stat_stall), n_stall);
`endif

      // Halt with three products in flight.
      rsp_ready = 1'b0;
      base = glog.size();
      add_op(0, 12, 12, 144);
      add_op(1, 500, 4, 2000);
      add_op(2, 2047, 2, 4094);
      tick(6);
      chk("halt_inflight", exp_q.size(), 3);
      add_op(3, 9, 9, 81);
      halt_req = 1'b1;
      tick(2);
      rsp_ready = 1'b1;
      for (int k = 0; k < 20 && !halted; k++) begin
         @(negedge clk);
         if (!halted) chk("drain_no_grant", 32'(req_ready), 0);
      end
      chk("halt_reached", 32'(halted), 1);
      chk("halt_grants", glog.size() - base, 3);
      chk("halt_delivered", exp_q.size(), 0);
      tick(1);
      halt_req = 1'b0;
      @(negedge clk);
      chk("halt_hold_halted", 32'(halted), 1);
      chk("halt_hold_ready", 32'(req_ready), 0);
      @(negedge clk);
      chk("resume_halted", 32'(halted), 0);
      chk("resume_ready", 32'(req_ready), 4'b1000);
      wait_idle("resume_done");

      // Halt while empty, raised in the same cycle as a pending request.
      chk_lat = 1'b1;
      add_op(1, 1000, 999, 999000);
      tick(1);
      halt_req = 1'b1;
      @(negedge clk);
      chk("halt_same_cycle_no_grant", 32'(req_ready), 0);
      @(negedge clk);
      chk("idle_halt_edge1", 32'(halted), 0);
      @(negedge clk);
      chk("idle_halt_edge2", 32'(halted), 1);
      tick(1);
      halt_req = 1'b0;
      wait_idle("idle_halt_done");

      // Reset mid-stream.
      for (int i = 0; i < N; i++) add_op(i, 7, i + 2, 7 * (i + 2));
      tick(3);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_reset_req_ready", 32'(req_ready), 0);
      chk("mid_reset_halted", 32'(halted), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) n_ops[i] = rd[i];
      n_rsp = 0;
      n_stall = 0;
      tick(2);
`ifdef MULT_STATS_EN
      chk("reset_stat_done", 32'(stat_done), 0);
      chk("reset_stat_stall", 32'(stat_stall), 0);
`endif
      rst_n = 1'b1;
      base = glog.size();
      for (int i = 0; i < N; i++) add_op(i, 2047 - i, 3, (2047 - i) * 3);
      wait_idle("post_reset_done");
      chk("post_reset_first_grant", glog[base].id, 0);
      chk("post_reset_rsp_count", n_rsp, 4);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
